// File: rtl/subtractor_32bit_serial.sv
// Lane-serial unsigned subtractor: one LANE-bit slice per clock, LSB slice first,
// borrow rippled through a register, valid/ready handshakes on both sides.
module subtractor_32bit_serial #(
    parameter int WIDTH = 32,
    parameter int LANE  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int NLANES = WIDTH / LANE;
    localparam int LIDX_W = (NLANES > 1) ? $clog2(NLANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [LIDX_W-1:0]   r_lane_idx;
    logic                r_borrow;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_diff;
    logic                r_borrow_out;
    logic                r_in_ready;
    logic                r_out_valid;

    logic [LANE-1:0]     w_a_slice;
    logic [LANE-1:0]     w_b_slice;
    logic [LANE:0]       w_sub;
    logic                w_last;

    // The single subtract cell: MSB of the LANE+1-bit result is the slice borrow.
    assign w_a_slice = r_a[int'(r_lane_idx) * LANE +: LANE];
    assign w_b_slice = r_b[int'(r_lane_idx) * LANE +: LANE];
    assign w_sub     = {1'b0, w_a_slice} - {1'b0, w_b_slice} - {{LANE{1'b0}}, r_borrow};
    assign w_last    = (r_lane_idx == LIDX_W'(NLANES - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: operand and result registers are reset too, so an aborted
            // operation leaves no stale data visible on diff.
            r_state      <= S_IDLE;
            r_lane_idx   <= '0;
            r_borrow     <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_lane_idx <= '0;
                        r_borrow   <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_diff[int'(r_lane_idx) * LANE +: LANE] <= w_sub[LANE-1:0];
                    r_borrow <= w_sub[LANE];
                    if (w_last) begin
                        r_borrow_out <= w_sub[LANE];
                        r_lane_idx   <= '0;
                        r_out_valid  <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_lane_idx <= r_lane_idx + LIDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_subtractor_32bit_serial.sv
// Directed-vector and randomized-stall bench for subtractor_32bit_serial
// (default WIDTH=32, LANE=8: four lanes, result four edges after accept).
module tb_subtractor_32bit_serial;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 4;
    localparam int NVEC    = 9;
    localparam int NRAND   = 1500;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] d;
        logic             bo;
    } vec_t;

    vec_t vecs [NVEC];

    subtractor_32bit_serial #(.WIDTH(32), .LANE(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete transaction: optional idle cycles, accept, latency/result checks,
    // out_ready stall in DONE, then handoff back to IDLE.
    task automatic run_op(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic [WIDTH-1:0] exp_d, input logic exp_bo,
                          input int pre_idle, input int out_stall);
        int   wait_cnt;
        int   lat;
        logic bad_ready;
        logic bad_hold;
        for (int i = 0; i < pre_idle; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a = $urandom;
            b = $urandom;
        end
        @(negedge clk);
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!in_ready) begin
            check({name, "_in_ready_timeout"}, 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1;
        a = ta;
        b = tb_;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        bad_ready = 1'b0;
        while (!out_valid && lat < 20) begin
            if (in_ready) bad_ready = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_in_ready_busy"}, 64'(bad_ready), 64'd0);
        check({name, "_latency"}, 64'(lat), 64'(LATENCY));
        check({name, "_diff"}, 64'(diff), 64'(exp_d));
        check({name, "_borrow"}, 64'(borrow_out), 64'(exp_bo));
        bad_hold = 1'b0;
        for (int i = 0; i < out_stall; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== exp_d || borrow_out !== exp_bo)
                bad_hold = 1'b1;
        end
        if (out_stall > 0) check({name, "_done_hold"}, 64'(bad_hold), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_handoff"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             bad_valid;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        vecs[0] = '{a: 32'h0000_0005, b: 32'h0000_0003, d: 32'h0000_0002, bo: 1'b0};
        vecs[1] = '{a: 32'h0000_0000, b: 32'h0000_0001, d: 32'hFFFF_FFFF, bo: 1'b1};
        vecs[2] = '{a: 32'h0001_0000, b: 32'h0000_0001, d: 32'h0000_FFFF, bo: 1'b0};
        vecs[3] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, d: 32'h0000_0000, bo: 1'b0};
        vecs[4] = '{a: 32'h1234_5678, b: 32'h1234_5679, d: 32'hFFFF_FFFF, bo: 1'b1};
        vecs[5] = '{a: 32'h8000_0000, b: 32'h0000_0001, d: 32'h7FFF_FFFF, bo: 1'b0};
        vecs[6] = '{a: 32'hDEAD_BEEF, b: 32'h1234_5678, d: 32'hCC79_6877, bo: 1'b0};
        vecs[7] = '{a: 32'h1234_5678, b: 32'hDEAD_BEEF, d: 32'h3386_9789, bo: 1'b1};
        vecs[8] = '{a: 32'h00FF_00FF, b: 32'h0100_0000, d: 32'hFFFF_00FF, bo: 1'b1};

        #12;
        check("reset_outputs", {31'd0, out_valid, in_ready, borrow_out, diff},
              {31'd0, 1'b0, 1'b1, 1'b0, 32'd0});
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, i % 3, 0);

        // Consumer stalls for 10 cycles in DONE.
        run_op("stall10", 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 0, 10);

        // Reset two cycles into BUSY discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_busy_outputs", {31'd0, out_valid, in_ready, borrow_out, diff},
              {31'd0, 1'b0, 1'b1, 1'b0, 32'd0});
        @(negedge clk);
        rst = 1'b0;
        bad_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) bad_valid = 1'b1;
        end
        check("rst_no_valid_pulse", 64'(bad_valid), 64'd0);
        run_op("after_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0, 0);

        // Randomized operands and stalls against a plain a-b model.
        for (int i = 0; i < NRAND; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) rb = ra + WIDTH'($urandom_range(0, 3));
            run_op($sformatf("rand%0d", i), ra, rb, ra - rb, (ra < rb),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
